// File: rtl/coin_pkg.sv
// Coin table shared definitions: entry field layout, scheduler states and power-up table.
package coin_pkg;

    localparam int unsigned COIN_W     = 16;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned TABLE_SIZE = 16;

    localparam int unsigned EXISTS_BIT = 15;
    localparam int unsigned X_MSB      = 14;
    localparam int unsigned X_LSB      = 7;
    localparam int unsigned Y_MSB      = 6;
    localparam int unsigned Y_LSB      = 0;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD,
        ST_CHK,
        ST_ERASE,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic           exists;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } coin_t;

    // Power-up coin layout; entries past the live count are never written.
    localparam logic [COIN_W-1:0] COIN_INIT [TABLE_SIZE] = '{
        16'hD35F,   // (166, 95)
        16'hCAAA,   // (149, 42)
        16'h850A,   // ( 10, 10)
        16'h9414,   // ( 40, 20)
        16'hA83C,   // ( 80, 60)
        16'hBC64,   // (120,100)
        16'hE405,   // (200,  5)
        16'h8F6E,   // ( 30,110)
        16'hEE46,   // (220, 70)
        16'hFF7F,   // (254,127)
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

    function automatic coin_t coin_decode(input logic [COIN_W-1:0] word);
        coin_t c;
        c.exists = word[EXISTS_BIT];
        c.x      = word[X_MSB:X_LSB];
        c.y      = word[Y_MSB:Y_LSB];
        return c;
    endfunction

    function automatic logic [COIN_W-1:0] coin_erase(input logic [COIN_W-1:0] word);
        logic [COIN_W-1:0] w;
        w             = word;
        w[EXISTS_BIT] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/coin_hit_test.sv
// Combinational player-hitbox versus coin overlap test.
module coin_hit_test
    import coin_pkg::*;
#(
    parameter int unsigned HIT_W = 4,
    parameter int unsigned HIT_H = 4
) (
    input  coin_t          coin,
    input  logic [X_W-1:0] px,
    input  logic [Y_W-1:0] py,
    output logic           hit_c
);

    localparam int unsigned XE_W = X_W + 1;
    localparam int unsigned YE_W = Y_W + 1;

    logic [XE_W-1:0] x_hi;
    logic [YE_W-1:0] y_hi;
    logic            x_in;
    logic            y_in;

    // One extra bit keeps the far edge from wrapping near the screen border.
    assign x_hi = {1'b0, px} + XE_W'(HIT_W);
    assign y_hi = {1'b0, py} + YE_W'(HIT_H);

    assign x_in = (px <= coin.x) && ({1'b0, coin.x} <= x_hi);
    assign y_in = (py <= coin.y) && ({1'b0, coin.y} <= y_hi);

    assign hit_c = coin.exists && x_in && y_in;

endmodule

// File: rtl/coin_table_scheduler.sv
// Coin RAM sequencer: power-up table load, per-frame collision scan with erase/score,
// and idle-cycle read sharing with the renderer.
module coin_table_scheduler
    import coin_pkg::*;
#(
    parameter int unsigned NUM_COINS = 10,
    parameter int unsigned HIT_W     = 4,
    parameter int unsigned HIT_H     = 4,
    parameter int unsigned SCORE_W   = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                frame_tick,
    input  logic [X_W-1:0]      player_x,
    input  logic [Y_W-1:0]      player_y,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wren,
    output logic [COIN_W-1:0]   mem_data,
    input  logic [COIN_W-1:0]   mem_q,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_grant,
    output logic                rd_valid,
    output logic [COIN_W-1:0]   rd_data,
    output logic [SCORE_W-1:0]  score,
    output logic                score_inc,
    output logic                all_collected,
    output logic                busy
);

    localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(NUM_COINS - 1);
    localparam logic [ADDR_W-1:0]  INIT_END  = ADDR_W'(NUM_COINS);
    localparam logic [ADDR_W-1:0]  IDX_ONE   = ADDR_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic                live;
    logic                tick_pend;
    coin_t               cur_coin;
    logic                hit;

    assign cur_coin = coin_decode(mem_q);
    assign rd_data  = mem_q;

    coin_hit_test #(
        .HIT_W (HIT_W),
        .HIT_H (HIT_H)
    ) u_hit (
        .coin  (cur_coin),
        .px    (player_x),
        .py    (player_y),
        .hit_c (hit)
    );

    // Memory-side outputs are loaded on entry to a state so they are valid during it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_INIT;
            idx           <= '0;
            live          <= 1'b0;
            tick_pend     <= 1'b0;
            mem_addr      <= '0;
            mem_wren      <= 1'b0;
            mem_data      <= '0;
            rd_grant      <= 1'b0;
            rd_valid      <= 1'b0;
            score         <= '0;
            score_inc     <= 1'b0;
            all_collected <= 1'b0;
            busy          <= 1'b1;
        end else begin
            mem_wren  <= 1'b0;
            score_inc <= 1'b0;
            rd_grant  <= 1'b0;
            rd_valid  <= rd_grant;

            // Single-deep tick memory while the table is occupied.
            if (frame_tick && (state != ST_IDLE)) begin
                tick_pend <= 1'b1;
            end

            case (state)
                ST_INIT: begin
                    if (idx == INIT_END) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        mem_wren <= 1'b1;
                        mem_addr <= idx;
                        mem_data <= COIN_INIT[idx[3:0]];
                        idx      <= idx + IDX_ONE;
                    end
                end

                ST_IDLE: begin
                    if (frame_tick || tick_pend) begin
                        tick_pend <= 1'b0;
                        idx       <= '0;
                        live      <= 1'b0;
                        mem_addr  <= '0;
                        busy      <= 1'b1;
                        state     <= ST_RD;
                    end else if (rd_req) begin
                        rd_grant <= 1'b1;
                        mem_addr <= rd_addr;
                    end
                end

                ST_RD: begin
                    state <= ST_CHK;
                end

                ST_CHK: begin
                    if (cur_coin.exists) begin
                        live <= 1'b1;
                    end
                    if (hit) begin
                        mem_wren  <= 1'b1;
                        mem_addr  <= idx;
                        mem_data  <= coin_erase(mem_q);
                        score_inc <= 1'b1;
                        if (score != SCORE_MAX) begin
                            score <= score + SCORE_ONE;
                        end
                        state <= ST_ERASE;
                    end else if (idx == LAST_IDX) begin
                        state <= ST_FIN;
                    end else begin
                        idx      <= idx + IDX_ONE;
                        mem_addr <= idx + IDX_ONE;
                        state    <= ST_RD;
                    end
                end

                ST_ERASE: begin
                    if (idx == LAST_IDX) begin
                        state <= ST_FIN;
                    end else begin
                        idx      <= idx + IDX_ONE;
                        mem_addr <= idx + IDX_ONE;
                        state    <= ST_RD;
                    end
                end

                ST_FIN: begin
                    if (!live) begin
                        all_collected <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
